// File: rtl/game_status.sv
// Per-level gameplay bookkeeping: level countdown, lives, end-of-level score tally,
// and the win / game-over levels handed to the screen state machine.
module game_status #(
  parameter int START_LIVES     = 3,
  parameter int START_TIME      = 400,
  parameter int FRAMES_PER_TICK = 24,
  parameter int DEATH_HOLD      = 120,
  parameter int TALLY_STEP      = 50
) (
  input  logic        frame_clk,
  input  logic        Reset,
  input  logic        game_active,
  input  logic        mario_dead,
  input  logic        flag_reached,
  output logic        freeze,
  output logic        respawn,
  output logic        game_over_screen,
  output logic        win,
  output logic [9:0]  time_left,
  output logic [2:0]  lives,
  output logic [19:0] score
);

  // state   | meaning
  // IDLE    | reloaded, waiting for the game screen
  // PLAY    | level running, time ticking
  // DYING   | death animation hold, gameplay frozen
  // RESPAWN | single frame returning Mario to the level start
  // TALLY   | converting remaining time into score
  // WON     | level cleared, win held until game screen exits
  // LOST    | out of lives, game over held until game screen exits
  typedef enum logic [2:0] {
    S_IDLE, S_PLAY, S_DYING, S_RESPAWN, S_TALLY, S_WON, S_LOST
  } state_t;

  localparam int TW = (FRAMES_PER_TICK > 1) ? $clog2(FRAMES_PER_TICK) : 1;
  localparam int HW = (DEATH_HOLD > 1) ? $clog2(DEATH_HOLD) : 1;
  localparam int STEP_C = (TALLY_STEP > 20'hFFFFF) ? 20'hFFFFF : TALLY_STEP;

  localparam logic [TW-1:0] TICK_LAST  = TW'(FRAMES_PER_TICK - 1);
  localparam logic [HW-1:0] HOLD_LAST  = HW'(DEATH_HOLD - 1);
  localparam logic [9:0]    TIME_INIT  = 10'(START_TIME);
  localparam logic [2:0]    LIVES_INIT = 3'(START_LIVES);
  localparam logic [20:0]   STEP_W     = 21'(STEP_C);

  state_t        state_q, state_d;
  logic [TW-1:0] tick_q, tick_d;
  logic [HW-1:0] hold_q, hold_d;
  logic [9:0]    time_d;
  logic [2:0]    lives_d;
  logic [19:0]   score_d;
  logic          dead_q, flag_q;
  logic          dead_ev, flag_ev;
  logic [20:0]   score_sum;

  assign dead_ev   = mario_dead & ~dead_q;
  assign flag_ev   = flag_reached & ~flag_q;
  assign score_sum = {1'b0, score} + STEP_W;

  always_ff @(posedge frame_clk) begin
    if (Reset) begin
      state_q   <= S_IDLE;
      tick_q    <= '0;
      hold_q    <= '0;
      time_left <= TIME_INIT;
      lives     <= LIVES_INIT;
      score     <= '0;
      dead_q    <= 1'b0;
      flag_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      tick_q    <= tick_d;
      hold_q    <= hold_d;
      time_left <= time_d;
      lives     <= lives_d;
      score     <= score_d;
      dead_q    <= mario_dead;
      flag_q    <= flag_reached;
    end
  end

  always_comb begin
    state_d = state_q;
    tick_d  = tick_q;
    hold_d  = hold_q;
    time_d  = time_left;
    lives_d = lives;
    score_d = score;

    if (!game_active || state_q == S_IDLE) begin
      state_d = (state_q == S_IDLE && game_active) ? S_PLAY : S_IDLE;
      tick_d  = '0;
      hold_d  = '0;
      time_d  = TIME_INIT;
      lives_d = LIVES_INIT;
      score_d = '0;
    end else begin
      case (state_q)
        S_PLAY: begin
          // an event frame freezes the clock; only a quiet frame advances time
          if (flag_ev) begin
            state_d = S_TALLY;
          end else if (dead_ev) begin
            state_d = S_DYING;
            hold_d  = '0;
          end else if (tick_q == TICK_LAST) begin
            tick_d = '0;
            if (time_left != 10'd0) time_d = time_left - 10'd1;
            if (time_left <= 10'd1) begin
              state_d = S_DYING;
              hold_d  = '0;
            end
          end else begin
            tick_d = tick_q + TW'(1);
          end
        end
        S_DYING: begin
          if (hold_q == HOLD_LAST) begin
            if (lives <= 3'd1) begin
              lives_d = 3'd0;
              state_d = S_LOST;
            end else begin
              lives_d = lives - 3'd1;
              time_d  = TIME_INIT;
              tick_d  = '0;
              state_d = S_RESPAWN;
            end
          end else begin
            hold_d = hold_q + HW'(1);
          end
        end
        S_RESPAWN: begin
          time_d  = TIME_INIT;
          tick_d  = '0;
          state_d = S_PLAY;
        end
        S_TALLY: begin
          if (time_left != 10'd0) begin
            time_d  = time_left - 10'd1;
            score_d = score_sum[20] ? 20'hFFFFF : score_sum[19:0];
          end
          if (time_left <= 10'd1) state_d = S_WON;
        end
        S_WON, S_LOST: state_d = state_q;
        default:       state_d = S_IDLE;
      endcase
    end
  end

  always_comb begin
    freeze           = (state_q == S_DYING) || (state_q == S_TALLY) ||
                       (state_q == S_WON)   || (state_q == S_LOST);
    respawn          = (state_q == S_RESPAWN);
    win              = (state_q == S_WON);
    game_over_screen = (state_q == S_LOST);
  end

endmodule

// File: tb/tb_game_status.sv
// Randomized scoreboard bench for game_status: three parameter sets driven in parallel
// and compared frame by frame against a rule-level reference model.
module tb_game_status;

  logic frame_clk = 1'b0;
  always #5 frame_clk = ~frame_clk;

  logic Reset, game_active, mario_dead, flag_reached;

  logic        f_o [3];
  logic        r_o [3];
  logic        g_o [3];
  logic        w_o [3];
  logic [9:0]  t_o [3];
  logic [2:0]  l_o [3];
  logic [19:0] s_o [3];

  game_status #(.START_LIVES(3), .START_TIME(400), .FRAMES_PER_TICK(24),
                .DEATH_HOLD(120), .TALLY_STEP(50)) u0 (
    .frame_clk(frame_clk), .Reset(Reset), .game_active(game_active),
    .mario_dead(mario_dead), .flag_reached(flag_reached), .freeze(f_o[0]),
    .respawn(r_o[0]), .game_over_screen(g_o[0]), .win(w_o[0]),
    .time_left(t_o[0]), .lives(l_o[0]), .score(s_o[0]));

  game_status #(.START_LIVES(2), .START_TIME(1), .FRAMES_PER_TICK(2),
                .DEATH_HOLD(3), .TALLY_STEP(50)) u1 (
    .frame_clk(frame_clk), .Reset(Reset), .game_active(game_active),
    .mario_dead(mario_dead), .flag_reached(flag_reached), .freeze(f_o[1]),
    .respawn(r_o[1]), .game_over_screen(g_o[1]), .win(w_o[1]),
    .time_left(t_o[1]), .lives(l_o[1]), .score(s_o[1]));

  game_status #(.START_LIVES(1), .START_TIME(30), .FRAMES_PER_TICK(1),
                .DEATH_HOLD(2), .TALLY_STEP(40000)) u2 (
    .frame_clk(frame_clk), .Reset(Reset), .game_active(game_active),
    .mario_dead(mario_dead), .flag_reached(flag_reached), .freeze(f_o[2]),
    .respawn(r_o[2]), .game_over_screen(g_o[2]), .win(w_o[2]),
    .time_left(t_o[2]), .lives(l_o[2]), .score(s_o[2]));

  int p_sl[3]   = '{3, 2, 1};
  int p_st[3]   = '{400, 1, 30};
  int p_fpt[3]  = '{24, 2, 1};
  int p_dh[3]   = '{120, 3, 2};
  int p_step[3] = '{50, 50, 40000};

  localparam int M_IDLE = 0, M_PLAY = 1, M_DYING = 2, M_RESP = 3,
                 M_TALLY = 4, M_WON = 5, M_LOST = 6;
  localparam int SCORE_MAX = 1048575;

  int m_mode[3], m_time[3], m_lives[3], m_score[3], m_tick[3], m_dleft[3];
  bit m_pd, m_pf;

  typedef struct packed {
    logic        freeze;
    logic        respawn;
    logic        gos;
    logic        win;
    logic [9:0]  t;
    logic [2:0]  l;
    logic [19:0] s;
  } obs_t;
  typedef obs_t [2:0] trio_t;

  trio_t sbq[$];
  int errors = 0;
  int checks = 0;

  task automatic reload(input int i);
    m_time[i]  = p_st[i];
    m_lives[i] = p_sl[i];
    m_score[i] = 0;
    m_tick[i]  = 0;
    m_dleft[i] = 0;
  endtask

  task automatic model_step(input logic r, input logic ga, input logic md, input logic fr);
    bit ed, ef;
    ed = md && !m_pd;
    ef = fr && !m_pf;
    if (r) begin
      for (int i = 0; i < 3; i++) begin
        reload(i);
        m_mode[i] = M_IDLE;
      end
      m_pd = 0;
      m_pf = 0;
      return;
    end
    m_pd = md;
    m_pf = fr;
    for (int i = 0; i < 3; i++) begin
      if (!ga || m_mode[i] == M_IDLE) begin
        int nxt;
        nxt = (m_mode[i] == M_IDLE && ga) ? M_PLAY : M_IDLE;
        reload(i);
        m_mode[i] = nxt;
      end else begin
        case (m_mode[i])
          M_PLAY: begin
            if (ef) m_mode[i] = M_TALLY;
            else if (ed) begin
              m_mode[i] = M_DYING;
              m_dleft[i] = p_dh[i];
            end else begin
              m_tick[i]++;
              if (m_tick[i] == p_fpt[i]) begin
                m_tick[i] = 0;
                if (m_time[i] > 0) m_time[i]--;
                if (m_time[i] == 0) begin
                  m_mode[i] = M_DYING;
                  m_dleft[i] = p_dh[i];
                end
              end
            end
          end
          M_DYING: begin
            m_dleft[i]--;
            if (m_dleft[i] == 0) begin
              m_lives[i]--;
              if (m_lives[i] == 0) m_mode[i] = M_LOST;
              else begin
                m_mode[i] = M_RESP;
                m_time[i] = p_st[i];
                m_tick[i] = 0;
              end
            end
          end
          M_RESP: begin
            m_time[i] = p_st[i];
            m_tick[i] = 0;
            m_mode[i] = M_PLAY;
          end
          M_TALLY: begin
            if (m_time[i] > 0) begin
              m_time[i]--;
              m_score[i] = m_score[i] + p_step[i];
              if (m_score[i] > SCORE_MAX) m_score[i] = SCORE_MAX;
            end
            if (m_time[i] == 0) m_mode[i] = M_WON;
          end
          default: ;
        endcase
      end
    end
  endtask

  function automatic obs_t expect_of(input int i);
    obs_t e;
    e.freeze  = (m_mode[i] == M_DYING) || (m_mode[i] == M_TALLY) ||
                (m_mode[i] == M_WON) || (m_mode[i] == M_LOST);
    e.respawn = (m_mode[i] == M_RESP);
    e.gos     = (m_mode[i] == M_LOST);
    e.win     = (m_mode[i] == M_WON);
    e.t       = 10'(m_time[i]);
    e.l       = 3'(m_lives[i]);
    e.s       = 20'(m_score[i]);
    return e;
  endfunction

  task automatic frame(input logic r, input logic ga, input logic md, input logic fr);
    trio_t tr;
    @(negedge frame_clk);
    Reset = r;
    game_active = ga;
    mario_dead = md;
    flag_reached = fr;
    @(posedge frame_clk);
    model_step(r, ga, md, fr);
    for (int i = 0; i < 3; i++) tr[i] = expect_of(i);
    sbq.push_back(tr);
  endtask

  task automatic play(input int n);
    repeat (n) frame(0, 1, 0, 0);
  endtask

  task automatic restart();
    repeat (2) frame(0, 0, 0, 0);
  endtask

  task automatic check(input string name, input int inst, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s inst=%0d time=%0t got=%0d expected=%0d", name, inst, $time, act, exp);
    end
  endtask

  // monitor: every frame the DUT presents a full set of outputs
  initial begin
    trio_t e;
    forever begin
      @(negedge frame_clk);
      if (sbq.size() > 0) begin
        e = sbq.pop_front();
        for (int i = 0; i < 3; i++) begin
          check("freeze", i, int'(f_o[i]), int'(e[i].freeze));
          check("respawn", i, int'(r_o[i]), int'(e[i].respawn));
          check("game_over_screen", i, int'(g_o[i]), int'(e[i].gos));
          check("win", i, int'(w_o[i]), int'(e[i].win));
          check("time_left", i, int'(t_o[i]), int'(e[i].t));
          check("lives", i, int'(l_o[i]), int'(e[i].l));
          check("score", i, int'(s_o[i]), int'(e[i].s));
        end
      end
    end
  end

  initial begin
    bit md_lvl;
    Reset = 1'b1;
    game_active = 1'b0;
    mario_dead = 1'b0;
    flag_reached = 1'b0;
    repeat (3) frame(1, 0, 0, 0);
    frame(0, 0, 0, 0);

    // countdown from the start of play
    play(60);

    // three deaths on the default set, then a death edge while lost
    for (int k = 0; k < 3; k++) begin
      repeat ($urandom_range(1, 4)) frame(0, 1, 1, 0);
      play($urandom_range(125, 160));
    end
    repeat (2) frame(0, 1, 1, 0);
    play(5);

    // flag with roughly ten time units left on the default set
    restart();
    play(9360 + $urandom_range(0, 30));
    frame(0, 1, 0, 1);
    play(30);
    restart();
    play($urandom_range(2, 20));
    frame(0, 1, 0, 1);
    play(420);

    // flag and death rising together
    restart();
    play($urandom_range(5, 30));
    frame(0, 1, 1, 1);
    play(20);

    // game screen left during the death hold
    restart();
    play(10);
    frame(0, 1, 1, 0);
    play($urandom_range(10, 100));
    repeat (3) frame(0, 0, 0, 0);
    play(5);

    // reset during the tally
    restart();
    play(10);
    frame(0, 1, 0, 1);
    play($urandom_range(5, 200));
    frame(1, 1, 0, 0);
    play(40);

    // random soak
    md_lvl = 0;
    game_active = 1'b1;
    for (int n = 0; n < 3000; n++) begin
      logic r, ga, fr;
      r  = ($urandom_range(0, 499) == 0);
      ga = game_active;
      if ($urandom_range(0, 299) == 0) ga = ~ga;
      if ($urandom_range(0, 39) == 0) md_lvl = ~md_lvl;
      fr = ($urandom_range(0, 149) == 0);
      frame(r, ga, md_lvl, fr);
    end

    frame(0, 0, 0, 0);
    repeat (2) @(negedge frame_clk);
    #1;
    checks++;
    if (sbq.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain got=%0d expected=0", sbq.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/game_status.md
# game_status

Per-level gameplay bookkeeping: owns the level countdown timer, the life counter and the score tally, and produces the `game_over_screen` and `win` levels consumed by the screen state machine. It sits directly upstream of the screen FSM and beside the Mario physics/collision logic. It advances only while `game_active` is high and reloads itself whenever `game_active` is low.

## Interface
- START_LIVES, 3, lives loaded on reload (1..7)
- START_TIME, 400, time units loaded on reload and on respawn (1..1023)
- FRAMES_PER_TICK, 24, frames per time-unit decrement (>=1)
- DEATH_HOLD, 120, frames gameplay is frozen after a death (>=1)
- TALLY_STEP, 50, points added per remaining time unit at level end

- frame_clk  in  1  frame clock, one rising edge per video frame; all state updates on this edge
- Reset  in  1  reset, synchronous, active-high
- game_active  in  1  high while the screen FSM is in its game screen
- mario_dead  in  1  level from collision logic; a rising edge is one death event
- flag_reached  in  1  level from collision logic; a rising edge ends the level as a win
- freeze  out  1  high while gameplay movement must halt (DYING, TALLY, WON, LOST)
- respawn  out  1  one-frame pulse that returns Mario to the level start
- game_over_screen  out  1  held high in LOST
- win  out  1  held high in WON
- time_left  out  10  remaining time units, unsigned binary
- lives  out  3  remaining lives
- score  out  20  unsigned score, saturating at 20'hFFFFF

## Operation
- States: IDLE, PLAY, DYING, RESPAWN, TALLY, WON, LOST.
- Edge detection: registered copies of `mario_dead` and `flag_reached`. An event is current=1 and previous=0. The previous copies update every frame in every state.
- Reload (state is IDLE, or `game_active`=0 in any state):
  - next state is IDLE
  - time_left=START_TIME, lives=START_LIVES, score=0, tick=0
  - all flag outputs 0
- IDLE -> PLAY when `game_active`=1.
- PLAY:
  - tick increments each frame.
  - At tick==FRAMES_PER_TICK-1, tick returns to 0 and time_left decrements. time_left never goes below 0.
  - Event priority within one frame: flag event, then death event, then time expiry.
  - Flag event -> TALLY.
  - Death event, or time_left at 0 after a decrement -> DYING, with the hold counter cleared.
- DYING: freeze=1. The hold counter increments each frame. At DEATH_HOLD-1:
  - lives==1 -> lives=0 and next state LOST.
  - otherwise lives decrements and next state is RESPAWN.
- RESPAWN (exactly one frame):
  - respawn=1
  - time_left=START_TIME, tick=0
  - next state PLAY
- TALLY: each frame with time_left>0, time_left decrements and score += TALLY_STEP (saturating). When time_left==0 on entry or after a step, next state is WON.
- WON: win=1 and freeze=1, held until `game_active`=0.
- LOST: game_over_screen=1 and freeze=1, held until `game_active`=0.
- Death and flag events are ignored outside PLAY.

## Timing
- Reset values: state IDLE, time_left=START_TIME, lives=START_LIVES, score=0, tick=0, hold=0, edge registers 0; freeze, respawn, win and game_over_screen are 0.
- All outputs are registered or decoded from the registered state. No combinational path from inputs to outputs.
- PLAY entry is 1 frame after `game_active` rises.
- The first time decrement comes FRAMES_PER_TICK frames after PLAY entry.
- A death edge at frame N gives freeze=1 at N+1.
- respawn pulses at N+1+DEATH_HOLD, and PLAY resumes one frame later.
- TALLY takes time_left frames, then 1 frame to WON.
- `win` and `game_over_screen` are guaranteed stable for at least one full frame before the screen FSM samples them. Both drop 1 frame after `game_active` falls.
- Reset mid-operation overrides all activity. Reset takes priority over `game_active`.

## Test plan
- Reset, then `game_active`=1 with FRAMES_PER_TICK=24 -> time_left reads 400 through frame 24 after PLAY entry, then 399. lives=3, score=0.
- `mario_dead` rising edge, DEATH_HOLD=120 -> freeze high 120 frames, then a one-frame respawn pulse. Afterwards lives=2, time_left=400, then PLAY.
- Three deaths from START_LIVES=3 -> the third hold ends in LOST with lives=0 and game_over_screen=1. A later `mario_dead` edge leaves lives=0.
- `flag_reached` edge with time_left=10 -> 10 TALLY frames, score=500, time_left=0, then win=1. With score preset near max, score saturates at 20'hFFFFF.
- `flag_reached` and `mario_dead` rise in the same frame -> TALLY taken and lives unchanged. Time expiry (START_TIME=1, FRAMES_PER_TICK=2) -> DYING after 2 PLAY frames.
- `game_active` dropped during DYING, and Reset asserted during TALLY -> IDLE next frame with all values reloaded and all flag outputs 0.
